// File: rtl/dly_credit_rx_if.sv
// rtl/dly_credit_rx_if.sv - handshake bundle between delay-chain sender, credit receiver and consumer
// Purpose : groups the beat input, FIFO drain port, credit return and status of dly_credit_rx.
// Signals : in_vld/in_data (beat from delay chain), out_vld/out_data/out_rdy (FIFO head drain),
//           credit_rtn (one credit per pulse), count (entries held), ovf (sticky overflow),
//           max_count (high-water mark, present only with DLY_CREDIT_RX_HWM_EN).
// Modports: slave = receiver (dly_credit_rx), master = environment (sender + consumer).
interface dly_credit_rx_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
);
  logic             in_vld;
  logic [WIDTH-1:0] in_data;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic             out_rdy;
  logic             credit_rtn;
  logic [CNT_W-1:0] count;
  logic             ovf;
`ifdef DLY_CREDIT_RX_HWM_EN
  logic [CNT_W-1:0] max_count;

  modport slave (
    input  in_vld, in_data, out_rdy,
    output out_vld, out_data, credit_rtn, count, ovf, max_count
  );
  modport master (
    output in_vld, in_data, out_rdy,
    input  out_vld, out_data, credit_rtn, count, ovf, max_count
  );
`else
  modport slave (
    input  in_vld, in_data, out_rdy,
    output out_vld, out_data, credit_rtn, count, ovf
  );
  modport master (
    output in_vld, in_data, out_rdy,
    input  out_vld, out_data, credit_rtn, count, ovf
  );
`endif
endinterface

// File: rtl/dly_credit_rx.sv
// rtl/dly_credit_rx.sv - credit-based receive FIFO at the end of a fixed-latency delay chain
// Purpose : captures every beat from the delay chain into a DEPTH-entry FIFO, drains it through
//           a valid/ready port and returns one registered credit pulse per beat popped.
// Ports   : clk  - single clock, posedge
//           rst  - asynchronous active-high reset
//           bus  - dly_credit_rx_if.slave (in_vld, in_data, out_vld, out_data, out_rdy,
//                  credit_rtn, count, ovf, and max_count when enabled)
// Config  : DLY_CREDIT_RX_HWM_EN defined adds the max_count high-water mark.
module dly_credit_rx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  dly_credit_rx_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_credit;
  logic             r_ovf;

  logic [CNT_W-1:0] w_count_nxt;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // Full/empty come from the count so the pointers may wrap freely.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = !w_empty && bus.out_rdy;
  // A pop frees the head slot in the same edge, so a full FIFO can still accept a beat.
  assign w_push  = bus.in_vld && (!w_full || w_pop);
  assign w_drop  = bus.in_vld && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count  <= w_count_nxt;
      r_credit <= w_pop;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage is deliberately not reset; stale entries are never visible because
  // out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  assign bus.out_vld    = !w_empty;
  assign bus.out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.credit_rtn = r_credit;
  assign bus.count      = r_count;
  assign bus.ovf        = r_ovf;

`ifdef DLY_CREDIT_RX_HWM_EN
  logic [CNT_W-1:0] r_max_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_count <= '0;
    end else if (w_count_nxt > r_max_count) begin
      r_max_count <= w_count_nxt;
    end
  end

  assign bus.max_count = r_max_count;
`endif
endmodule
